// File: rtl/crosswalk_req_scheduler.sv
// Pedestrian-button front end: synchroniser, debouncer, request latch and walk handshake.
// Optional ack-timeout retry is enabled by defining REQ_TIMEOUT_EN.
module crosswalk_req_scheduler #(
    parameter int unsigned DEB_CYCLES  = 10000,
    parameter int unsigned MIN_GREEN   = 5000000,
    parameter int unsigned HOLDOFF     = 3000000,
    parameter int unsigned ACK_TIMEOUT = 1000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_n,
    input  logic       car_green,
    input  logic       grant_ack,
    input  logic       walk_done,
    output logic       grant_req,
    output logic       wait_led,
    output logic [7:0] req_cnt,
    output logic       timeout_err
);

    typedef enum logic [2:0] {StIdle, StArmed, StReq, StWalk, StHold} state_e;

    localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] MinGreen = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLDOFF - 1);

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             pend_q, pend_d;
    logic [7:0]       req_cnt_q, req_cnt_d;
    logic             grant_req_q, grant_req_d;
    logic             wait_led_q, wait_led_d;
    logic             green_ok;

`ifdef REQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] AckLast = CNT_W'(ACK_TIMEOUT - 1);
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // Debouncer runs regardless of en; press is a registered one-cycle pulse on 1->0.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        press_d = deb_q & ~deb_d;
    end

    assign green_ok = (green_cnt_q == MinGreen);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        hold_cnt_d  = '0;
        green_cnt_d = '0;
        req_cnt_d   = req_cnt_q;
`ifdef REQ_TIMEOUT_EN
        ack_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
`endif
        if (en) begin
            if (press_q && req_cnt_q != 8'hff) begin
                req_cnt_d = req_cnt_q + 8'd1;
            end
            if (car_green) begin
                green_cnt_d = green_ok ? green_cnt_q : green_cnt_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (press_q) state_d = StArmed;
                end
                StArmed: begin
                    if (green_ok) state_d = StReq;
                end
                StReq: begin
                    if (grant_ack) begin
                        state_d = StWalk;
                    end else begin
`ifdef REQ_TIMEOUT_EN
                        // Green timer is kept, so ARMED re-requests at once if still green.
                        if (ack_cnt_q == AckLast) begin
                            state_d       = StArmed;
                            timeout_err_d = 1'b1;
                        end else begin
                            ack_cnt_d = ack_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                StWalk: begin
                    if (press_q) pend_d = 1'b1;
                    if (walk_done) state_d = StHold;
                end
                StHold: begin
                    if (press_q) pend_d = 1'b1;
                    if (hold_cnt_q == HoldLast) begin
                        state_d = (pend_q || press_q) ? StArmed : StIdle;
                        pend_d  = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else begin
            state_d = StIdle;
            pend_d  = 1'b0;
        end
        grant_req_d = (state_d == StReq);
        wait_led_d  = (state_d == StArmed) || (state_d == StReq) || (state_d == StWalk);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            deb_q       <= 1'b1;
            deb_cnt_q   <= '0;
            press_q     <= 1'b0;
            green_cnt_q <= '0;
            hold_cnt_q  <= '0;
            pend_q      <= 1'b0;
            req_cnt_q   <= '0;
            grant_req_q <= 1'b0;
            wait_led_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
            green_cnt_q <= green_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            pend_q      <= pend_d;
            req_cnt_q   <= req_cnt_d;
            grant_req_q <= grant_req_d;
            wait_led_q  <= wait_led_d;
        end
    end

`ifdef REQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            ack_cnt_q     <= ack_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant_req = grant_req_q;
    assign wait_led  = wait_led_q;
    assign req_cnt   = req_cnt_q;

endmodule

// File: tb/tb_crosswalk_req_scheduler.sv
// Directed bench for crosswalk_req_scheduler with small timing parameters.
// Timeout expectations follow REQ_TIMEOUT_EN when the macro is defined.
module tb_crosswalk_req_scheduler;

`ifdef REQ_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, btn_n, car_green, grant_ack, walk_done;
    logic       grant_req, wait_led, timeout_err;
    logic [7:0] req_cnt;

    int n_vec = 0;
    int n_err = 0;

    crosswalk_req_scheduler #(
        .DEB_CYCLES (4),
        .MIN_GREEN  (20),
        .HOLDOFF    (10),
        .ACK_TIMEOUT(8),
        .CNT_W      (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .btn_n      (btn_n),
        .car_green  (car_green),
        .grant_ack  (grant_ack),
        .walk_done  (walk_done),
        .grant_req  (grant_req),
        .wait_led   (wait_led),
        .req_cnt    (req_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_release(input int lo, input int hi);
        btn_n = 1'b0;
        tick(lo);
        btn_n = 1'b1;
        tick(hi);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; btn_n = 1'b1; car_green = 1'b0; grant_ack = 1'b0;
        walk_done = 1'b0;
        tick(3);
        check("rst_grant_req", 32'(grant_req), 32'd0);
        check("rst_wait_led", 32'(wait_led), 32'd0);
        check("rst_req_cnt", 32'(req_cnt), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick(1);

        // Bounce: toggles every 2 cycles never satisfy the 4-cycle debounce.
        for (int i = 0; i < 10; i++) begin
            btn_n = i[0];
            tick(2);
        end
        check("bounce_no_press", 32'(req_cnt), 32'd0);
        btn_n = 1'b0;
        tick(6);
        check("press_lat_cnt", 32'(req_cnt), 32'd0);
        check("press_lat_led", 32'(wait_led), 32'd0);
        tick(1);
        check("press_cnt", 32'(req_cnt), 32'd1);
        check("press_armed", 32'(wait_led), 32'd1);
        tick(10);
        check("held_one_press", 32'(req_cnt), 32'd1);
        btn_n = 1'b1;
        tick(8);

        // Green interrupted after 12 cycles; needs 20 fresh consecutive cycles.
        car_green = 1'b1;
        tick(12);
        check("green12_no_req", 32'(grant_req), 32'd0);
        car_green = 1'b0;
        tick(2);
        car_green = 1'b1;
        tick(20);
        check("green20_no_req_yet", 32'(grant_req), 32'd0);
        tick(1);
        check("green_req", 32'(grant_req), 32'd1);
        check("req_led", 32'(wait_led), 32'd1);

        // en low for one cycle while in REQ.
        en = 1'b0;
        tick(1);
        check("en0_grant_req", 32'(grant_req), 32'd0);
        check("en0_idle", 32'(wait_led), 32'd0);
        check("en0_req_cnt", 32'(req_cnt), 32'd1);
        en = 1'b1;

        // Press with car_green already high; green timer restarted by en=0.
        btn_n = 1'b0;
        tick(7);
        check("p2_armed", 32'(wait_led), 32'd1);
        check("p2_cnt", 32'(req_cnt), 32'd2);
        check("p2_no_req", 32'(grant_req), 32'd0);
        btn_n = 1'b1;
        tick(13);
        check("p2_req_early", 32'(grant_req), 32'd0);
        tick(1);
        check("p2_req", 32'(grant_req), 32'd1);
        tick(2);
        check("p2_req_held", 32'(grant_req), 32'd1);
        grant_ack = 1'b1;
        tick(1);
        check("ack_drops_req", 32'(grant_req), 32'd0);
        check("walk_led", 32'(wait_led), 32'd1);
        grant_ack = 1'b0;

        // Press coinciding with walk_done: HOLD with pend, then back to ARMED.
        btn_n = 1'b0;
        tick(6);
        walk_done = 1'b1;
        tick(1);
        walk_done = 1'b0;
        btn_n = 1'b1;
        check("hold_led", 32'(wait_led), 32'd0);
        check("hold_cnt3", 32'(req_cnt), 32'd3);
        tick(9);
        check("hold_end_led", 32'(wait_led), 32'd0);
        tick(1);
        check("hold_to_armed", 32'(wait_led), 32'd1);
        tick(1);
        check("pend_re_req", 32'(grant_req), 32'd1);
        grant_ack = 1'b1;
        tick(1);
        grant_ack = 1'b0;
        walk_done = 1'b1;
        tick(1);
        walk_done = 1'b0;
        tick(10);
        check("pend_cleared_idle", 32'(wait_led), 32'd0);
        tick(3);
        check("idle_no_req", 32'(grant_req), 32'd0);

        // Stray handshake inputs in IDLE are ignored.
        walk_done = 1'b1;
        grant_ack = 1'b1;
        tick(1);
        walk_done = 1'b0;
        grant_ack = 1'b0;
        check("stray_ignored", 32'(wait_led), 32'd0);

        // Presses with en low are neither counted nor latched.
        en = 1'b0;
        press_release(8, 8);
        check("en0_press_cnt", 32'(req_cnt), 32'd3);
        check("en0_press_led", 32'(wait_led), 32'd0);
        en = 1'b1;
        tick(3);
        check("en0_not_latched", 32'(wait_led), 32'd0);

        // Saturation: 300 presses in total.
        for (int i = 0; i < 252; i++) press_release(8, 8);
        check("cnt_255", 32'(req_cnt), 32'd255);
        for (int i = 0; i < 45; i++) press_release(8, 8);
        check("cnt_sat", 32'(req_cnt), 32'd255);

        rst = 1'b1;
        tick(1);
        check("rst2_req_cnt", 32'(req_cnt), 32'd0);
        check("rst2_grant_req", 32'(grant_req), 32'd0);
        rst = 1'b0;
        car_green = 1'b0;
        tick(2);

        // Ack timeout behaviour (or indefinite wait when the feature is absent).
        car_green = 1'b1;
        btn_n = 1'b0;
        tick(7);
        check("to_armed", 32'(wait_led), 32'd1);
        btn_n = 1'b1;
        tick(14);
        check("to_req", 32'(grant_req), 32'd1);
        tick(7);
        check("to_req_7", 32'(grant_req), 32'd1);
        check("to_err_7", 32'(timeout_err), 32'd0);
        tick(1);
        check("to_req_8", 32'(grant_req), ToEn ? 32'd0 : 32'd1);
        check("to_err_8", 32'(timeout_err), 32'(ToEn));
        check("to_led_8", 32'(wait_led), 32'd1);
        tick(1);
        check("to_retry", 32'(grant_req), 32'd1);
        check("to_err_sticky", 32'(timeout_err), 32'(ToEn));
        rst = 1'b1;
        tick(1);
        check("rst_clears_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
